// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 4-bit ALU: registers operands, waits a settle time,
// captures Result/Carry, returns them over a response handshake and self-checks against a golden model.
module alu_cmd_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [1:0]       cmd_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [1:0]       alu_op,
  input  logic [3:0]       alu_result,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_result,
  output logic             rsp_carry,
  output logic             err_mismatch,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] settle_cnt;
  logic       accept, capture, rsp_fire;
  logic [4:0] golden_val;
  logic       mismatch;

  function automatic logic [4:0] golden(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op);
    case (op)
      2'b00:   golden = {1'b0, a} + {1'b0, b};
      2'b01:   golden = {1'b0, a} - {1'b0, b};
      2'b10:   golden = {1'b0, a & b};
      default: golden = {1'b0, a | b};
    endcase
  endfunction

  // The ALU leaves carry undriven for logic ops, so it is only meaningful for add/sub.
  function automatic logic mask_carry(input logic [1:0] op, input logic carry);
    mask_carry = op[1] ? 1'b0 : carry;
  endfunction

  assign golden_val = golden(alu_a, alu_b, alu_op);
  assign mismatch   = (alu_result != golden_val[3:0]) ||
                      (!alu_op[1] && (alu_carry != golden_val[4]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    rsp_fire  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = rst_n;
        if (cmd_valid && rst_n) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (settle_cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand issue / settle count / result capture stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a        <= 4'd0;
      alu_b        <= 4'd0;
      alu_op       <= 2'd0;
      settle_cnt   <= 4'd0;
      rsp_result   <= 4'd0;
      rsp_carry    <= 1'b0;
      rsp_valid    <= 1'b0;
      err_mismatch <= 1'b0;
      ops_done     <= '0;
    end else begin
      if (accept) begin
        alu_a      <= cmd_a;
        alu_b      <= cmd_b;
        alu_op     <= cmd_op;
        settle_cnt <= SETTLE_M1;
      end else if ((state == ISSUE) && (settle_cnt != 4'd0)) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      if (capture) begin
        rsp_result <= alu_result;
        rsp_carry  <= mask_carry(alu_op, alu_carry);
        rsp_valid  <= 1'b1;
        if (mismatch) err_mismatch <= 1'b1;
      end
      if (rsp_fire) begin
        rsp_valid <= 1'b0;
        ops_done  <= ops_done + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Sequential front-end that drives the team's 4-bit combinational ALU. It accepts operation commands over a valid/ready handshake, presents registered operands and opcodes to the ALU, waits a programmable settle time, and captures Result/Carry. It returns the captured result over a second valid/ready handshake. An internal golden model checks every captured result and flags mismatches. The block sits between a command source (test controller or CPU-side logic) and the ALU instance.

Parameters:
SETTLE_CYCLES, 1, number of cycles operands are held at the ALU before capture (legal 1..15)
CNT_W, 8, width of completed-operation counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_a  input  4  operand A
cmd_b  input  4  operand B
cmd_op  input  2  00 add, 01 sub, 10 AND, 11 OR
alu_a  output  4  registered operand A to ALU
alu_b  output  4  registered operand B to ALU
alu_op  output  2  registered opcode to ALU
alu_result  input  4  ALU Result
alu_carry  input  1  ALU Carry
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  4  captured result
rsp_carry  output  1  captured carry (masked to 0 for logic ops)
err_mismatch  output  1  sticky: captured result differed from golden model
ops_done  output  CNT_W  count of completed response handshakes

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. alu_a, alu_b, alu_op, rsp_result, rsp_carry, rsp_valid, err_mismatch and ops_done all 0. cmd_ready is 0 while rst_n is low.
- States: IDLE, ISSUE, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready at edge k:
  - register cmd_a/b/op into alu_a/b/op;
  - load settle counter with SETTLE_CYCLES-1;
  - go to ISSUE.
- ISSUE: cmd_ready=0 and alu_* held stable. Counter decrements each cycle. In the cycle with counter==0, at the next edge:
  - sample alu_result into rsp_result;
  - sample carry into rsp_carry: alu_carry for op 00/01, forced 0 for op 10/11, because the ALU carry is not driven for logic ops;
  - set rsp_valid=1 and go to RESP.
- Latency: rsp_valid rises at edge k+SETTLE_CYCLES after command acceptance at edge k.
- Golden check, on the capture edge:
  - expected 5-bit value = A+B (00), A-B mod 32 (01), A&B (10), A|B (11);
  - compare rsp_result with the low 4 bits, and compare carry with bit 4 for op 00/01 only;
  - any difference sets err_mismatch, which stays set until reset.
- Sub carry: 1 when A<B (borrow), e.g. 3-5 gives result 4'hE, carry 1.
- RESP: cmd_ready=0. rsp_valid, rsp_result and rsp_carry are held stable until rsp_ready=1. On rsp_valid&&rsp_ready at an edge:
  - rsp_valid drops to 0;
  - ops_done increments, wrapping from 2^CNT_W-1 to 0;
  - state goes to IDLE.
- No command is accepted in the same cycle as a response handshake. Max throughput is one op per SETTLE_CYCLES+2 cycles.
- alu_a/b/op retain their last values in IDLE and RESP. rsp_result/carry retain their values after the handshake.
- cmd_valid in ISSUE/RESP is ignored (cmd_ready=0). The source must hold cmd_valid and payload stable until accepted.
- Reset mid-operation: an in-flight command is discarded and no response is produced. All outputs return to reset values immediately.
- rsp_ready high while rsp_valid is low has no effect.

Test Plan:
- Add, SETTLE_CYCLES=1: cmd 9+8 op 00 accepted at edge k -> rsp_valid at edge k+1, rsp_result=1, rsp_carry=1, err_mismatch=0, ops_done=1 after handshake.
- Sub borrow: A=3, B=5, op 01 -> rsp_result=4'hE, rsp_carry=1. A=7, B=2 -> 5, carry 0.
- Logic carry mask: A=4'hF, B=4'h5, op 10, with the ALU model holding alu_carry=1 -> rsp_result=5, rsp_carry=0, err_mismatch=0. Then OR 4'hA|4'h5 -> 4'hF, carry 0.
- Backpressure, SETTLE_CYCLES=3:
  - rsp_ready held low 5 cycles: rsp_valid stays 1, payload stable, cmd_ready stays 0 with cmd_valid high;
  - rsp_valid rises exactly 3 cycles after acceptance;
  - the next command is accepted one cycle after the handshake.
- Error and reset:
  - ALU model corrupts result to 0 for 6+1 -> err_mismatch=1 and stays 1 through later correct ops;
  - asserting rst_n low mid-ISSUE -> all outputs 0 at once, no response after release, err_mismatch cleared;
  - running 256 ops with CNT_W=8 -> ops_done wraps to 0.
